// File: rtl/alu_word_sequencer_pkg.sv
// Shared opcodes, FSM states and helpers for the multi-word ALU sequencer.
package alu_word_sequencer_pkg;

   localparam logic [3:0] OpPass = 4'b0000;
   localparam logic [3:0] OpAdd  = 4'b0001;
   localparam logic [3:0] OpAdc  = 4'b0010;
   localparam logic [3:0] OpSub  = 4'b0011;
   localparam logic [3:0] OpSbb  = 4'b0100;
   localparam logic [3:0] OpInc  = 4'b0101;
   localparam logic [3:0] OpDec  = 4'b0110;
   localparam logic [3:0] OpOr   = 4'b1000;
   localparam logic [3:0] OpXor  = 4'b1001;
   localparam logic [3:0] OpAnd  = 4'b1010;
   localparam logic [3:0] OpNot  = 4'b1011;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_t;

   // Only ADC/SBB seed the carry chain from the external carry-in.
   function automatic logic op_uses_cin(input logic [3:0] op);
      return (op == OpAdc) || (op == OpSbb);
   endfunction

endpackage

// File: rtl/alu_word_sequencer_slice.sv
// Combinational DATA_SIZE-bit ALU slice; arithmetic is done DATA_SIZE+1 bits wide.
module alu_word_sequencer_slice
   import alu_word_sequencer_pkg::*;
#(
   parameter int unsigned DATA_SIZE = 8
) (
   input  logic [DATA_SIZE-1:0] a_in,
   input  logic [DATA_SIZE-1:0] b_in,
   input  logic                 cin_in,
   input  logic [3:0]           op_in,
   output logic [DATA_SIZE-1:0] result_out,
   output logic                 co_out
);

   logic [DATA_SIZE:0] w_wide;

   always_comb begin
      w_wide     = '0;
      result_out = '0;
      co_out     = 1'b0;
      case (op_in)
         OpPass: result_out = a_in;
         OpAdc: begin
            w_wide     = {1'b0, a_in} + {1'b0, b_in} + {{DATA_SIZE{1'b0}}, cin_in};
            result_out = w_wide[DATA_SIZE-1:0];
            co_out     = w_wide[DATA_SIZE];
         end
         // MSB of the widened difference is the borrow out
         OpSbb: begin
            w_wide     = {1'b0, a_in} - {1'b0, b_in} - {{DATA_SIZE{1'b0}}, cin_in};
            result_out = w_wide[DATA_SIZE-1:0];
            co_out     = w_wide[DATA_SIZE];
         end
         OpOr:  result_out = a_in | b_in;
         OpXor: result_out = a_in ^ b_in;
         OpAnd: result_out = a_in & b_in;
         OpNot: result_out = ~a_in;
         default: begin
            result_out = '0;
            co_out     = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_word_sequencer.sv
// Sequences one wide ALU command as WORDS slice operations, LS word first, carry chained.
module alu_word_sequencer
   import alu_word_sequencer_pkg::*;
#(
   parameter int unsigned DATA_SIZE    = 8,
   parameter int unsigned WORDS        = 4,
   parameter int unsigned OP_CODE_SIZE = 4
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   input  logic [OP_CODE_SIZE-1:0]      op_code_in,
   input  logic [DATA_SIZE*WORDS-1:0]   a_in,
   input  logic [DATA_SIZE*WORDS-1:0]   b_in,
   input  logic                         cin_in,
   output logic                         ready_out,
   output logic                         valid_out,
   output logic [DATA_SIZE*WORDS-1:0]   result_out,
   output logic                         co_out
);

   localparam int unsigned W    = DATA_SIZE * WORDS;
   localparam int unsigned IdxW = $clog2(WORDS);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

   state_t                  r_state;
   state_t                  w_state_next;
   logic [3:0]              r_op;
   logic [W-1:0]            r_a;
   logic [W-1:0]            r_b;
   logic [W-1:0]            r_work;
   logic [W-1:0]            r_result;
   logic                    r_co;
   logic                    r_carry;
   logic [IdxW-1:0]         r_index;

   logic [3:0]              w_slice_op;
   logic [DATA_SIZE-1:0]    w_slice_b;
   logic                    w_slice_cin;
   logic [DATA_SIZE-1:0]    w_slice_res;
   logic                    w_slice_co;
   logic [W-1:0]            w_work_next;
   logic                    w_last;

   // Operands shift right each slice, so the active slice is always the low word.
   alu_word_sequencer_slice #(
      .DATA_SIZE (DATA_SIZE)
   ) u_slice (
      .a_in       (r_a[DATA_SIZE-1:0]),
      .b_in       (w_slice_b),
      .cin_in     (w_slice_cin),
      .op_in      (w_slice_op),
      .result_out (w_slice_res),
      .co_out     (w_slice_co)
   );

   assign w_last      = (r_index == LastIdx);
   assign w_work_next = {w_slice_res, r_work[W-1:DATA_SIZE]};

   // ADD/SUB/INC/DEC reuse the carry-chained ADC/SBB slice ops.
   always_comb begin
      w_slice_op  = r_op;
      w_slice_b   = r_b[DATA_SIZE-1:0];
      w_slice_cin = r_carry;
      case (r_op)
         OpAdd: w_slice_op = OpAdc;
         OpSub: w_slice_op = OpSbb;
         OpInc: begin
            w_slice_op  = OpAdc;
            w_slice_b   = '0;
            w_slice_cin = (r_index == '0) ? 1'b1 : r_carry;
         end
         OpDec: begin
            w_slice_op  = OpSbb;
            w_slice_b   = '0;
            w_slice_cin = (r_index == '0) ? 1'b1 : r_carry;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (start_in) w_state_next = StRun;
         StRun:   if (w_last) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state  <= StIdle;
         r_op     <= OpPass;
         r_a      <= '0;
         r_b      <= '0;
         r_work   <= '0;
         r_result <= '0;
         r_co     <= 1'b0;
         r_carry  <= 1'b0;
         r_index  <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            StIdle: begin
               if (start_in) begin
                  r_op    <= op_code_in[3:0];
                  r_a     <= a_in;
                  r_b     <= b_in;
                  r_index <= '0;
                  r_carry <= op_uses_cin(op_code_in[3:0]) ? cin_in : 1'b0;
               end
            end
            StRun: begin
               r_a     <= r_a >> DATA_SIZE;
               r_b     <= r_b >> DATA_SIZE;
               r_work  <= w_work_next;
               r_carry <= w_slice_co;
               r_index <= r_index + IdxW'(1);
               if (w_last) begin
                  r_result <= w_work_next;
                  r_co     <= w_slice_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign ready_out  = (r_state == StIdle);
   assign valid_out  = (r_state == StDone);
   assign result_out = r_result;
   assign co_out     = r_co;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Self-checking bench: directed and random commands against a full-width arithmetic model.
module tb_alu_word_sequencer;

   localparam int unsigned DATA_SIZE = 8;
   localparam int unsigned WORDS     = 4;
   localparam int unsigned W         = DATA_SIZE * WORDS;

   logic           clk_in;
   logic           rst_in;
   logic           start_in;
   logic [3:0]     op_code_in;
   logic [W-1:0]   a_in;
   logic [W-1:0]   b_in;
   logic           cin_in;
   logic           ready_out;
   logic           valid_out;
   logic [W-1:0]   result_out;
   logic           co_out;

   int             n_checks;
   int             n_errors;
   logic [W-1:0]   last_res;
   logic           last_co;

   alu_word_sequencer #(
      .DATA_SIZE    (DATA_SIZE),
      .WORDS        (WORDS),
      .OP_CODE_SIZE (4)
   ) u_dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .start_in   (start_in),
      .op_code_in (op_code_in),
      .a_in       (a_in),
      .b_in       (b_in),
      .cin_in     (cin_in),
      .ready_out  (ready_out),
      .valid_out  (valid_out),
      .result_out (result_out),
      .co_out     (co_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Whole-operand arithmetic; bit W carries the final carry or borrow.
   function automatic logic [W:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic cin);
      logic [W:0] r;
      r = '0;
      case (op)
         4'h0: r = {1'b0, a};
         4'h1: r = {1'b0, a} + {1'b0, b};
         4'h2: r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
         4'h3: r = {1'b0, a} - {1'b0, b};
         4'h4: r = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
         4'h5: r = {1'b0, a} + (W+1)'(1);
         4'h6: r = {1'b0, a} - (W+1)'(1);
         4'h8: r = {1'b0, a | b};
         4'h9: r = {1'b0, a ^ b};
         4'hA: r = {1'b0, a & b};
         4'hB: r = {1'b0, ~a};
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic run_cmd(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin, input bit hold_start);
      logic [W:0] exp;
      exp = ref_model(op, a, b, cin);
      check_eq({tag, "_ready_pre"}, 64'(ready_out), 64'd1);
      start_in   = 1'b1;
      op_code_in = op;
      a_in       = a;
      b_in       = b;
      cin_in     = cin;
      @(posedge clk_in);
      #1;
      if (!hold_start) start_in = 1'b0;
      a_in       = $urandom;
      b_in       = $urandom;
      op_code_in = 4'($urandom);
      cin_in     = 1'($urandom);
      for (int k = 1; k <= WORDS + 1; k++) begin
         @(posedge clk_in);
         #1;
         check_eq({tag, "_valid"}, 64'(valid_out), 64'(k == WORDS));
         check_eq({tag, "_ready"}, 64'(ready_out), 64'(k == WORDS + 1));
         if (k >= WORDS) begin
            check_eq({tag, "_result"}, 64'(result_out), 64'(exp[W-1:0]));
            check_eq({tag, "_co"}, 64'(co_out), 64'(exp[W]));
         end else begin
            check_eq({tag, "_held_res"}, 64'(result_out), 64'(last_res));
            check_eq({tag, "_held_co"}, 64'(co_out), 64'(last_co));
         end
         if (k == WORDS) start_in = 1'b0;
      end
      last_res = exp[W-1:0];
      last_co  = exp[W];
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_ready"}, 64'(ready_out), 64'd1);
      check_eq({tag, "_valid"}, 64'(valid_out), 64'd0);
      check_eq({tag, "_result"}, 64'(result_out), 64'd0);
      check_eq({tag, "_co"}, 64'(co_out), 64'd0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk_in);
         #1;
         check_eq({tag, "_no_valid"}, 64'(valid_out), 64'd0);
         check_eq({tag, "_result"}, 64'(result_out), 64'd0);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      last_res   = '0;
      last_co    = 1'b0;
      rst_in     = 1'b1;
      start_in   = 1'b0;
      op_code_in = 4'h0;
      a_in       = '0;
      b_in       = '0;
      cin_in     = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      check_reset_state("reset");

      run_cmd("add_ff_1",  4'h1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      run_cmd("add_wrap",  4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      run_cmd("inc_wrap",  4'h5, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      run_cmd("sub_100_1", 4'h3, 32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0);
      run_cmd("dec_wrap",  4'h6, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0);
      run_cmd("adc_cin",   4'h2, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
      run_cmd("sbb_cin",   4'h4, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0);
      run_cmd("xor",       4'h9, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b0);
      run_cmd("op_0111",   4'h7, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0);
      run_cmd("start_hold", 4'h1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      run_cmd("sub_borrow", 4'h3, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);

      // Abort in the second RUN cycle; result must clear with no completion pulse.
      start_in   = 1'b1;
      op_code_in = 4'h1;
      a_in       = 32'h0102_0304;
      b_in       = 32'h1111_1111;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      rst_in   = 1'b0;
      last_res = '0;
      last_co  = 1'b0;
      check_reset_state("mid_rst");
      expect_quiet("mid_rst", WORDS + 2);

      // Reset and start on the same edge: the command is dropped.
      run_cmd("pre_drop", 4'hB, 32'h0F0F_0000, 32'h0, 1'b0, 1'b0);
      rst_in     = 1'b1;
      start_in   = 1'b1;
      op_code_in = 4'h1;
      a_in       = 32'h0000_0001;
      b_in       = 32'h0000_0001;
      @(posedge clk_in);
      #1;
      rst_in   = 1'b0;
      start_in = 1'b0;
      last_res = '0;
      last_co  = 1'b0;
      check_reset_state("rst_start");
      expect_quiet("rst_start", WORDS + 2);

      for (int i = 0; i < 40; i++) begin
         run_cmd("rand", 4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                 1'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
